// File: rtl/des_round_controller.sv
// Iterative DES controller. A single shared Feistel round runs once per clock for 16 clocks,
// and each round's subkey is generated on the fly from the rotating C/D halves.

module feistel_function (
  input  logic [31:0] r_in,
  input  logic [47:0] subkey,
  output logic [31:0] f_out
);
  localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                              16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int P_T [32] = '{16,7,20,21, 29,12,28,17, 1,15,23,26, 5,18,31,10,
                              2,8,24,14, 32,27,3,9, 19,13,30,6, 22,11,4,25};
  // Each S-box is stored row-major, so {b1,b6,b2..b5} of the 6-bit group is the direct index.
  localparam int SBOX [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,   0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,   15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,   3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,   13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,   13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,   1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,   13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,   3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,   14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,   11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,   10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,   4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,   13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,   6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,   1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,   2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
  };

  logic [47:0] expanded;
  logic [47:0] mixed;
  logic [5:0]  six;
  logic [31:0] s_out;

  // NOTE: every variable written in always_comb is given a default first, so no path can infer a latch.
  always_comb begin
    expanded = '0;
    for (int i = 0; i < 48; i++) expanded[47-i] = r_in[32-E_T[i]];
    mixed = expanded ^ subkey;
    six   = '0;
    s_out = '0;
    for (int j = 0; j < 8; j++) begin
      six = mixed[47-6*j -: 6];
      s_out[31-4*j -: 4] = 4'(SBOX[j][{six[5], six[0], six[4:1]}]);
    end
    f_out = '0;
    for (int i = 0; i < 32; i++) f_out[31-i] = s_out[32-P_T[i]];
  end
endmodule

module des_round_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_decrypt,
  input  logic [63:0] in_block,
  input  logic [63:0] in_key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_block,
  output logic        busy
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                               62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                               57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                               61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                               38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                               36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                               34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                                10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                                63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                                41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int SHIFT_T [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  function automatic logic [63:0] ip(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
    return y;
  endfunction

  function automatic logic [63:0] fp(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
    return y;
  endfunction

  function automatic logic [55:0] pc1(input logic [63:0] x);
    logic [55:0] y;
    for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
    return y;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
    return y;
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] x, input int n);
    case (n)
      1:       return {x[26:0], x[27]};
      2:       return {x[25:0], x[27:26]};
      default: return x;
    endcase
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] x, input int n);
    case (n)
      1:       return {x[0], x[27:1]};
      2:       return {x[1:0], x[27:2]};
      default: return x;
    endcase
  endfunction

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] l_q, l_d, r_q, r_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic        mode_q, mode_d;
  logic [63:0] out_block_q, out_block_d;

  logic [27:0] c_rot, d_rot;
  logic [47:0] round_key;
  logic [31:0] feistel_output;

  // Decryption walks the schedule backwards: round 1 uses the unrotated PC1 halves (subkey 16).
  always_comb begin
    c_rot = c_q;
    d_rot = d_q;
    if (!mode_q) begin
      c_rot = rotl(c_q, SHIFT_T[cnt_q]);
      d_rot = rotl(d_q, SHIFT_T[cnt_q]);
    end else if (cnt_q != 4'd0) begin
      c_rot = rotr(c_q, SHIFT_T[16-int'(cnt_q)]);
      d_rot = rotr(d_q, SHIFT_T[16-int'(cnt_q)]);
    end
    round_key = pc2({c_rot, d_rot});
  end

  feistel_function u_feistel (
    .r_in   (r_q),
    .subkey (round_key),
    .f_out  (feistel_output)
  );

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_block = out_block_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    l_d         = l_q;
    r_d         = r_q;
    c_d         = c_q;
    d_d         = d_q;
    mode_d      = mode_q;
    out_block_d = out_block_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          {l_d, r_d} = ip(in_block);
          {c_d, d_d} = pc1(in_key);
          mode_d     = in_decrypt;
          cnt_d      = '0;
          state_d    = S_ROUND;
        end
      end
      S_ROUND: begin
        c_d   = c_rot;
        d_d   = d_rot;
        l_d   = r_q;
        r_d   = l_q ^ feistel_output;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          // Final round output is swapped back (R16 || L16) before the inverse permutation.
          out_block_d = fp({l_q ^ feistel_output, r_q});
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      l_q         <= '0;
      r_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      mode_q      <= 1'b0;
      out_block_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      l_q         <= l_d;
      r_q         <= r_d;
      c_q         <= c_d;
      d_q         <= d_d;
      mode_q      <= mode_d;
      out_block_q <= out_block_d;
    end
  end
endmodule
